// File: rtl/core_quant.sv
// core_quant: requantization and packing stage downstream of core_acc.
// Each valid accumulator value gets bias, scale, shift, zero point and
// saturation applied, then PACK_NUM results are packed into one word.
// Build option: define QUANT_ROUND_EN for round-half-up before the shift;
// without it the shift floors toward minus infinity.
module core_quant #(
   parameter int IDATA_BIT = 32,
   parameter int ODATA_BIT = 8,
   parameter int SCALE_BIT = 16,
   parameter int SHIFT_BIT = 5,
   parameter int PACK_NUM  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [IDATA_BIT-1:0]          cfg_quant_bias,
   input  logic [SCALE_BIT-1:0]          cfg_quant_scale,
   input  logic [SHIFT_BIT-1:0]          cfg_quant_shift,
   input  logic [ODATA_BIT-1:0]          cfg_quant_zp,
   input  logic [IDATA_BIT-1:0]          idata,
   input  logic                          idata_valid,
   input  logic                          pack_flush,
   output logic [ODATA_BIT*PACK_NUM-1:0] odata,
   output logic                          odata_valid
);

   localparam int BW = IDATA_BIT + 1;         // biased value
   localparam int PW = BW + SCALE_BIT;        // full-precision product
   localparam int QW = PW + 2;                // product + guard + zp headroom
   localparam int CW = $clog2(PACK_NUM);
   localparam logic signed [QW-1:0] QMAX = QW'((2 ** (ODATA_BIT - 1)) - 1);
   localparam logic signed [QW-1:0] QMIN = ~QMAX;

   // ---------------- S1: bias ----------------
   logic signed [BW-1:0] b_d, b_q;
   logic                 v1_q;

   assign b_d = BW'($signed(idata)) + BW'($signed(cfg_quant_bias));

   // register biased value with its valid
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         b_q  <= '0;
         v1_q <= 1'b0;
      end else begin
         v1_q <= idata_valid;
         if (idata_valid) b_q <= b_d;
      end
   end

   // ---------------- S2: scale ----------------
   logic signed [PW-1:0] p_d, p_q;
   logic                 v2_q;

   // both operands widened to the product width so the signed product is exact
   assign p_d = PW'(b_q) * PW'($signed(cfg_quant_scale));

   // register full-precision product with its valid
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_q  <= '0;
         v2_q <= 1'b0;
      end else begin
         v2_q <= v1_q;
         if (v1_q) p_q <= p_d;
      end
   end

   // ---------------- S3: shift, zero point, saturate ----------------
   logic signed [PW:0]    pg_w, r_w;
   logic signed [QW-1:0]  q_w;
   logic [ODATA_BIT-1:0]  sat_w, q_q;
   logic                  v3_q;

   // rounding (optional), arithmetic shift, zero point, clamp to output range
   always_comb begin
      pg_w = (PW+1)'(p_q);
`ifdef QUANT_ROUND_EN
      if (cfg_quant_shift != '0)
         pg_w = pg_w + ((PW+1)'(1) <<< (cfg_quant_shift - SHIFT_BIT'(1)));
`endif
      r_w = pg_w >>> cfg_quant_shift;
      q_w = QW'(r_w) + QW'($signed(cfg_quant_zp));
      if (q_w > QMAX)      sat_w = QMAX[ODATA_BIT-1:0];
      else if (q_w < QMIN) sat_w = QMIN[ODATA_BIT-1:0];
      else                 sat_w = q_w[ODATA_BIT-1:0];
   end

   // register saturated lane value with its valid
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q  <= '0;
         v3_q <= 1'b0;
      end else begin
         v3_q <= v2_q;
         if (v2_q) q_q <= sat_w;
      end
   end

   // ---------------- S4: packer ----------------
   logic [PACK_NUM-1:0][ODATA_BIT-1:0] buf_d, buf_q, lane_w, odata_d, odata_q;
   logic [CW-1:0]                      cnt_d, cnt_q;
   logic                               emit_w;

   // write incoming lane first, then emit on full word or on a non-empty flush
   always_comb begin
      lane_w  = buf_q;
      buf_d   = buf_q;
      cnt_d   = cnt_q;
      odata_d = odata_q;
      if (v3_q) lane_w[cnt_q] = q_q;
      emit_w = (v3_q && (cnt_q == CW'(PACK_NUM - 1))) ||
               (pack_flush && (v3_q || (cnt_q != '0)));
      if (emit_w) begin
         odata_d = lane_w;
         buf_d   = '0;
         cnt_d   = '0;
      end else if (v3_q) begin
         buf_d = lane_w;
         cnt_d = cnt_q + CW'(1);
      end
   end

   // packer state and registered output word / pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_q       <= '0;
         cnt_q       <= '0;
         odata_q     <= '0;
         odata_valid <= 1'b0;
      end else begin
         buf_q       <= buf_d;
         cnt_q       <= cnt_d;
         odata_q     <= odata_d;
         odata_valid <= emit_w;
      end
   end

   assign odata = odata_q;

endmodule

// File: tb/tb_core_quant.sv
// Scoreboard bench for core_quant: the driver feeds a behavioural model that
// predicts packed words and their pulse cycle; a monitor checks every pulse.
module tb_core_quant;
   localparam int IB = 32, OB = 8, SB = 16, HB = 5, PN = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [IB-1:0]   bias = '0, idata = '0;
   logic [SB-1:0]   scale = '0;
   logic [HB-1:0]   shift = '0;
   logic [OB-1:0]   zp = '0;
   logic            idata_valid = 1'b0, pack_flush = 1'b0;
   logic [OB*PN-1:0] odata;
   logic            odata_valid;

   core_quant #(.IDATA_BIT(IB), .ODATA_BIT(OB), .SCALE_BIT(SB),
                .SHIFT_BIT(HB), .PACK_NUM(PN)) dut (
      .clk(clk), .rst(rst),
      .cfg_quant_bias(bias), .cfg_quant_scale(scale),
      .cfg_quant_shift(shift), .cfg_quant_zp(zp),
      .idata(idata), .idata_valid(idata_valid), .pack_flush(pack_flush),
      .odata(odata), .odata_valid(odata_valid));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0, n_err = 0;

   logic [31:0] exp_d[$];
   int          exp_c[$];
   int          pend_c[$];
   logic [7:0]  pend_v[$];
   logic [7:0]  mbuf[$];

   task automatic chk(string nm, logic [63:0] act, logic [63:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   // reference quantizer: plain integer arithmetic on 64-bit values
   function automatic logic [7:0] quant(logic [31:0] x);
      longint b, p, r, q;
      b = longint'($signed(x)) + longint'($signed(bias));
      p = b * longint'($signed(scale));
`ifdef QUANT_ROUND_EN
      if (shift != 0) p = p + (longint'(1) << (shift - 1));
`endif
      r = p >>> shift;
      q = r + longint'($signed(zp));
      if (q > 127) q = 127;
      else if (q < -128) q = -128;
      return q[7:0];
   endfunction

   task automatic emit_word(int c);
      logic [31:0] w;
      w = '0;
      for (int i = 0; i < mbuf.size(); i++) w[8*i +: 8] = mbuf[i];
      exp_d.push_back(w);
      exp_c.push_back(c + 1);
      mbuf.delete();
   endtask

   // a value issued in cycle c is in the packer in cycle c+3
   task automatic model_step(int c, logic v, logic [31:0] x, logic f);
      if (pend_c.size() > 0 && pend_c[0] == c) begin
         mbuf.push_back(pend_v[0]);
         void'(pend_c.pop_front());
         void'(pend_v.pop_front());
         if (mbuf.size() == PN) emit_word(c);
      end
      if (f && mbuf.size() > 0) emit_word(c);
      if (v) begin
         pend_c.push_back(c + 3);
         pend_v.push_back(quant(x));
      end
   endtask

   task automatic tick(logic v, logic [31:0] x, logic f);
      @(posedge clk); #1;
      idata_valid = v;
      idata       = x;
      pack_flush  = f;
      model_step(cyc, v, x, f);
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0);
   endtask

   task automatic setcfg(logic [31:0] b, logic [15:0] s, logic [4:0] h, logic [7:0] z);
      idle(4);
      bias = b; scale = s; shift = h; zp = z;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; idata_valid = 1'b0; pack_flush = 1'b0;
      pend_c.delete(); pend_v.delete(); mbuf.delete();
      exp_d.delete(); exp_c.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      chk("reset_odata", 64'(odata), 64'd0);
      chk("reset_valid", 64'(odata_valid), 64'd0);
   endtask

   // monitor: every pulse must match the oldest prediction in data and cycle
   always @(negedge clk) begin
      if (!rst && odata_valid) begin
         if (exp_d.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_pulse: got odata %h expected no pulse (cycle %0d)", odata, cyc);
         end else begin
            chk("odata", 64'(odata), 64'(exp_d[0]));
            chk("pulse_cycle", 64'(cyc), 64'(exp_c[0]));
            void'(exp_d.pop_front());
            void'(exp_c.pop_front());
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("init_odata", 64'(odata), 64'd0);
      chk("init_valid", 64'(odata_valid), 64'd0);

      // simple pack 1..4
      setcfg(32'd0, 16'd1, 5'd0, 8'd0);
      tick(1, 1, 0); tick(1, 2, 0); tick(1, 3, 0); tick(1, 4, 0);
      idle(6);
      chk("tp_pack4", 64'(odata), 64'h04030201);

      // rounding vs floor on +-5 >> 1
      setcfg(32'd0, 16'd1, 5'd1, 8'd0);
      tick(1, 5, 0); tick(1, -5, 0); idle(2); tick(0, 0, 1); idle(2);
`ifdef QUANT_ROUND_EN
      chk("tp_round", 64'(odata), 64'h0000FE03);
`else
      chk("tp_floor", 64'(odata), 64'h0000FD02);
`endif

      // saturation cases
      setcfg(32'd0, 16'd1, 5'd0, 8'd0);
      tick(1, 1000, 0); tick(1, -1000, 0); idle(2); tick(0, 0, 1); idle(2);
      chk("tp_sat", 64'(odata), 64'h0000807F);
      setcfg(32'd0, 16'd1, 5'd0, 8'd10);
      tick(1, 120, 0); idle(2); tick(0, 0, 1); idle(2);
      chk("tp_sat_zp", 64'(odata), 64'h0000007F);
      setcfg(-32'd100, 16'd1, 5'd0, 8'd0);
      tick(1, 50, 0); idle(2); tick(0, 0, 1); idle(2);
      chk("tp_bias", 64'(odata), 64'h000000CE);

      // partial flush, then flush of an empty buffer
      setcfg(32'd0, 16'd1, 5'd0, 8'd0);
      tick(1, 7, 0); tick(1, 8, 0); idle(2); tick(0, 0, 1); idle(4);
      chk("tp_flush", 64'(odata), 64'h00000807);
      tick(0, 0, 1); idle(3);

      // 1..8 back to back, flush coincident with the 4th lane
      for (int i = 1; i <= 8; i++) tick(1, i, (i == 7));
      idle(6);
      chk("tp_pack8", 64'(odata), 64'h08070605);

      // reset with two lanes buffered
      tick(1, 1, 0); tick(1, 2, 0); idle(3);
      do_reset();
      for (int i = 9; i <= 12; i++) tick(1, i, 0);
      idle(6);
      chk("tp_post_reset", 64'(odata), 64'h0C0B0A09);

      // randomized phases
      for (int ph = 0; ph < 24; ph++) begin
         if (ph % 2 == 0)
            setcfg($urandom, 16'($urandom), 5'($urandom_range(0, 31)), 8'($urandom));
         else
            setcfg(32'($urandom_range(0, 200)) - 32'd100, 16'($urandom_range(0, 64)) - 16'd32,
                   5'($urandom_range(0, 4)), 8'($urandom_range(0, 40)) - 8'd20);
         for (int i = 0; i < 40; i++) begin
            logic [31:0] x;
            x = (ph % 2 == 0) ? $urandom : (32'($urandom_range(0, 400)) - 32'd200);
            tick($urandom_range(0, 9) < 7, x, $urandom_range(0, 9) == 0);
         end
         if (ph == 11) do_reset();
      end

      idle(6); tick(0, 0, 1); idle(6);
      chk("queue_empty", 64'(exp_d.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/core_quant.md
# core_quant

Requantization and packing stage that sits directly downstream of the accumulation block (`core_acc`). It consumes each 32-bit accumulated partial sum and converts it to a low-precision output value, one value at a time:
- add a bias;
- multiply by a signed scale;
- arithmetic right shift;
- add a zero point;
- saturate to a narrow signed output.

It then packs PACK_NUM consecutive results into one wide word for the downstream buffer/writeback path.

## Interface
Parameters:
- IDATA_BIT, 32, width of accumulated input (signed)
- ODATA_BIT, 8, width of each quantized lane (signed)
- SCALE_BIT, 16, width of scale multiplier (signed)
- SHIFT_BIT, 5, width of shift amount (unsigned)
- PACK_NUM, 4, lanes per packed output word (≥2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- cfg_quant_bias  in  IDATA_BIT  signed bias added to input
- cfg_quant_scale  in  SCALE_BIT  signed multiplier
- cfg_quant_shift  in  SHIFT_BIT  arithmetic right-shift amount
- cfg_quant_zp  in  ODATA_BIT  signed zero point added after shift
- idata  in  IDATA_BIT  accumulated value (signed)
- idata_valid  in  1  idata qualifier; any cycle, no backpressure
- pack_flush  in  1  single-cycle pulse; emit a partially filled word
- odata  out  ODATA_BIT*PACK_NUM  packed word; lane 0 = bits [ODATA_BIT-1:0] = earliest value
- odata_valid  out  1  one-cycle pulse per emitted word

## Operation
- Stage S1: b = sign-extended idata + cfg_quant_bias, IDATA_BIT+1 bits, registered with valid.
- Stage S2: p = b × cfg_quant_scale, IDATA_BIT+1+SCALE_BIT bits signed, full precision, registered with valid.
- Stage S3:
  - r = p >>> cfg_quant_shift (arithmetic), with rounding per Configuration.
  - q = r + sign-extended cfg_quant_zp.
  - Saturate q to [-2^(ODATA_BIT-1), 2^(ODATA_BIT-1)-1]; register with valid.
- Stage S4 (packer):
  - Lane counter cnt in 0..PACK_NUM-1, plus lane buffer.
  - On S3 valid, write lane[cnt].
  - If cnt==PACK_NUM-1: drive odata with the full buffer, pulse odata_valid, clear the buffer to zero, set cnt←0.
  - Otherwise cnt←cnt+1.
- Flush:
  - pack_flush is sampled in the S4 cycle.
  - Any S3-valid lane in that cycle is written first.
  - If at least one lane is then filled, emit the word with unfilled lanes = 0, clear the buffer, set cnt←0.
  - If zero lanes are filled, flush is ignored and no pulse is produced.
  - If flush coincides with a full-word completion, exactly one pulse is emitted.
- odata holds its last value between pulses.
- All cfg_* inputs must stay stable while any pipeline stage is valid. Results are undefined otherwise.
- No backpressure: every valid input produces exactly one lane.

## Timing
- Reset values:
  - odata = 0, odata_valid = 0.
  - All stage registers and valids = 0.
  - cnt = 0, lane buffer = 0.
- Latency: with idata_valid high in cycle n, the lane is written at the end of cycle n+3. If it completes a word, odata_valid is high in cycle n+4.
- Throughput: one input per cycle. Continuous input yields one odata_valid pulse every PACK_NUM cycles.
- Flush:
  - pack_flush in cycle m with buffered lanes gives odata_valid in cycle m+1.
  - To include an input from cycle n, flush no earlier than cycle n+3.
- Reset mid-operation: in-flight stage data and partial lanes are discarded and no pulse is emitted. The first post-reset input lands in lane 0.
- Shift of 0: no rounding term; r = p.

## Configuration
- Macro QUANT_ROUND_EN.
- Defined: round-half-up. Before the shift, add 2^(cfg_quant_shift-1) to p when cfg_quant_shift>0. The add is in p's width plus one guard bit.
- Undefined: plain arithmetic shift, i.e. floor toward −∞.
- Latency is identical in both builds.

## Test plan
- Bias 0, scale 1, shift 0, zp 0; inputs 1,2,3,4 in consecutive cycles (n..n+3) → odata=0x04030201, odata_valid high only in cycle n+7.
- Scale 1, shift 1:
  - idata=5 → lane 3 with QUANT_ROUND_EN, 2 without.
  - idata=-5 → -2 with, -3 without.
- Saturation, scale 1, shift 0:
  - idata=1000 → 0x7F; idata=-1000 → 0x80.
  - zp=10 with idata=120 → 0x7F.
  - bias=-100 with idata=50 → 0xCE.
- Inputs 7,8 then pack_flush 3 cycles after the last input → single pulse, odata=0x00000807. A second flush with an empty buffer → no pulse.
- 8 back-to-back inputs 1..8 → two pulses 4 cycles apart: 0x04030201 then 0x08070605. Flush coincident with the 4th lane → still one pulse.
- Assert rst after 2 lanes are buffered, then input 4 values → one pulse containing only the new 4 values, no stale lanes.
